// File: rtl/tlb_array.sv
// Fully associative MIPS TLB: two combinational lookup ports, tlbwi write, tlbr read, invalidate-all sweep.
// Optional macro TLB_MULTIHIT_CHECK_EN enables the s0_multi/s1_multi multiple-match flags.
module tlb_array #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    // lookup port 0 (fetch)
    input  logic [18:0]     s0_vpn2,
    input  logic            s0_odd_page,
    input  logic [7:0]      s0_asid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_pfn,
    output logic [2:0]      s0_c,
    output logic            s0_d,
    output logic            s0_v,
    output logic            s0_multi,
    // lookup port 1 (data / tlbp)
    input  logic [18:0]     s1_vpn2,
    input  logic            s1_odd_page,
    input  logic [7:0]      s1_asid,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_pfn,
    output logic [2:0]      s1_c,
    output logic            s1_d,
    output logic            s1_v,
    output logic            s1_multi,
    // write port (tlbwi)
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic [18:0]     w_vpn2,
    input  logic [7:0]      w_asid,
    input  logic            w_g,
    input  logic [19:0]     w_pfn0,
    input  logic [2:0]      w_c0,
    input  logic            w_d0,
    input  logic            w_v0,
    input  logic [19:0]     w_pfn1,
    input  logic [2:0]      w_c1,
    input  logic            w_d1,
    input  logic            w_v1,
    // read port (tlbr)
    input  logic [IDXW-1:0] r_index,
    output logic [18:0]     r_vpn2,
    output logic [7:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_pfn0,
    output logic [2:0]      r_c0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_pfn1,
    output logic [2:0]      r_c1,
    output logic            r_d1,
    output logic            r_v1,
    // invalidate-all sweep
    input  logic            invall_req,
    output logic            invall_busy,
    output logic            invall_done
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    state_t          state_reg;
    logic [IDXW-1:0] ptr_reg;

    logic        e_reg    [TLBNUM];
    logic [18:0] vpn2_reg [TLBNUM];
    logic [7:0]  asid_reg [TLBNUM];
    logic        g_reg    [TLBNUM];
    logic [19:0] pfn0_reg [TLBNUM];
    logic [2:0]  c0_reg   [TLBNUM];
    logic        d0_reg   [TLBNUM];
    logic        v0_reg   [TLBNUM];
    logic [19:0] pfn1_reg [TLBNUM];
    logic [2:0]  c1_reg   [TLBNUM];
    logic        d1_reg   [TLBNUM];
    logic        v1_reg   [TLBNUM];

    logic [TLBNUM-1:0] s0_match;
    logic [TLBNUM-1:0] s1_match;
    logic [IDXW-1:0]   s0_first;
    logic [IDXW-1:0]   s1_first;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                e_reg[i]    <= 1'b0;
                vpn2_reg[i] <= '0;
                asid_reg[i] <= '0;
                g_reg[i]    <= 1'b0;
                pfn0_reg[i] <= '0;
                c0_reg[i]   <= '0;
                d0_reg[i]   <= 1'b0;
                v0_reg[i]   <= 1'b0;
                pfn1_reg[i] <= '0;
                c1_reg[i]   <= '0;
                d1_reg[i]   <= 1'b0;
                v1_reg[i]   <= 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    ptr_reg <= '0;
                    if (invall_req) begin
                        state_reg <= SWEEP;
                    end
                end
                SWEEP: begin
                    ptr_reg <= ptr_reg + 1'b1;
                    if (ptr_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A write landing on the entry being swept this cycle takes priority.
            for (int i = 0; i < TLBNUM; i++) begin
                if (we && (w_index == IDXW'(i))) begin
                    e_reg[i]    <= 1'b1;
                    vpn2_reg[i] <= w_vpn2;
                    asid_reg[i] <= w_asid;
                    g_reg[i]    <= w_g;
                    pfn0_reg[i] <= w_pfn0;
                    c0_reg[i]   <= w_c0;
                    d0_reg[i]   <= w_d0;
                    v0_reg[i]   <= w_v0;
                    pfn1_reg[i] <= w_pfn1;
                    c1_reg[i]   <= w_c1;
                    d1_reg[i]   <= w_d1;
                    v1_reg[i]   <= w_v1;
                end else if ((state_reg == SWEEP) && (ptr_reg == IDXW'(i))) begin
                    e_reg[i]  <= 1'b0;
                    v0_reg[i] <= 1'b0;
                    v1_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign invall_busy = (state_reg == SWEEP);
    assign invall_done = (state_reg == SWEEP) && (ptr_reg == LAST_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < TLBNUM; gi++) begin : g_match
            assign s0_match[gi] = e_reg[gi] && (vpn2_reg[gi] == s0_vpn2) &&
                                  (g_reg[gi] || (asid_reg[gi] == s0_asid));
            assign s1_match[gi] = e_reg[gi] && (vpn2_reg[gi] == s1_vpn2) &&
                                  (g_reg[gi] || (asid_reg[gi] == s1_asid));
        end
    endgenerate

    function automatic logic [IDXW-1:0] first_set(input logic [TLBNUM-1:0] m);
        first_set = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) first_set = IDXW'(i);
        end
    endfunction

    assign s0_first = first_set(s0_match);
    assign s1_first = first_set(s1_match);
    assign s0_found = |s0_match;
    assign s1_found = |s1_match;
    assign s0_index = s0_first;
    assign s1_index = s1_first;

    always_comb begin
        s0_pfn = '0;
        s0_c   = '0;
        s0_d   = 1'b0;
        s0_v   = 1'b0;
        if (s0_found) begin
            s0_pfn = s0_odd_page ? pfn1_reg[s0_first] : pfn0_reg[s0_first];
            s0_c   = s0_odd_page ? c1_reg[s0_first]   : c0_reg[s0_first];
            s0_d   = s0_odd_page ? d1_reg[s0_first]   : d0_reg[s0_first];
            s0_v   = s0_odd_page ? v1_reg[s0_first]   : v0_reg[s0_first];
        end
    end

    always_comb begin
        s1_pfn = '0;
        s1_c   = '0;
        s1_d   = 1'b0;
        s1_v   = 1'b0;
        if (s1_found) begin
            s1_pfn = s1_odd_page ? pfn1_reg[s1_first] : pfn0_reg[s1_first];
            s1_c   = s1_odd_page ? c1_reg[s1_first]   : c0_reg[s1_first];
            s1_d   = s1_odd_page ? d1_reg[s1_first]   : d0_reg[s1_first];
            s1_v   = s1_odd_page ? v1_reg[s1_first]   : v0_reg[s1_first];
        end
    end

`ifdef TLB_MULTIHIT_CHECK_EN
    // m & (m-1) is non-zero exactly when two or more bits are set.
    assign s0_multi = |(s0_match & (s0_match - TLBNUM'(1)));
    assign s1_multi = |(s1_match & (s1_match - TLBNUM'(1)));
`else
    assign s0_multi = 1'b0;
    assign s1_multi = 1'b0;
`endif

    assign r_vpn2 = vpn2_reg[r_index];
    assign r_asid = asid_reg[r_index];
    assign r_g    = g_reg[r_index];
    assign r_pfn0 = pfn0_reg[r_index];
    assign r_c0   = c0_reg[r_index];
    assign r_d0   = d0_reg[r_index];
    assign r_v0   = v0_reg[r_index];
    assign r_pfn1 = pfn1_reg[r_index];
    assign r_c1   = c1_reg[r_index];
    assign r_d1   = d1_reg[r_index];
    assign r_v1   = v1_reg[r_index];

endmodule

// File: tb/tb_tlb_array.sv
// Self-checking bench for tlb_array: table-driven lookups through a scoreboard queue plus sweep/reset sequences.
module tb_tlb_array;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;
`ifdef TLB_MULTIHIT_CHECK_EN
    localparam logic MH = 1'b1;
`else
    localparam logic MH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic [18:0]     s0_vpn2, s1_vpn2;
    logic            s0_odd_page, s1_odd_page;
    logic [7:0]      s0_asid, s1_asid;
    logic            s0_found, s1_found;
    logic [IDXW-1:0] s0_index, s1_index;
    logic [19:0]     s0_pfn, s1_pfn;
    logic [2:0]      s0_c, s1_c;
    logic            s0_d, s1_d, s0_v, s1_v, s0_multi, s1_multi;
    logic            we;
    logic [IDXW-1:0] w_index;
    logic [18:0]     w_vpn2;
    logic [7:0]      w_asid;
    logic            w_g;
    logic [19:0]     w_pfn0, w_pfn1;
    logic [2:0]      w_c0, w_c1;
    logic            w_d0, w_v0, w_d1, w_v1;
    logic [IDXW-1:0] r_index;
    logic [18:0]     r_vpn2;
    logic [7:0]      r_asid;
    logic            r_g;
    logic [19:0]     r_pfn0, r_pfn1;
    logic [2:0]      r_c0, r_c1;
    logic            r_d0, r_v0, r_d1, r_v1;
    logic            invall_req, invall_busy, invall_done;

    tlb_array #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c),
        .s0_d(s0_d), .s0_v(s0_v), .s0_multi(s0_multi),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c),
        .s1_d(s1_d), .s1_v(s1_v), .s1_multi(s1_multi),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .invall_req(invall_req), .invall_busy(invall_busy), .invall_done(invall_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic        found;
        logic [3:0]  idx;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        multi;
    } lk_t;

    lk_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive both lookup ports, queue the expectation, compare when sampled on the falling edge.
    task automatic lookup(input string tag, input lk_t v);
        lk_t e;
        s0_vpn2 = v.vpn2; s0_odd_page = v.odd; s0_asid = v.asid;
        s1_vpn2 = v.vpn2; s1_odd_page = v.odd; s1_asid = v.asid;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, " s0_found"}, s0_found, e.found);
        check({tag, " s0_index"}, s0_index, e.idx);
        check({tag, " s0_pfn"},   s0_pfn,   e.pfn);
        check({tag, " s0_c"},     s0_c,     e.c);
        check({tag, " s0_d"},     s0_d,     e.d);
        check({tag, " s0_v"},     s0_v,     e.v);
        check({tag, " s0_multi"}, s0_multi, e.multi);
        check({tag, " s1_found"}, s1_found, e.found);
        check({tag, " s1_index"}, s1_index, e.idx);
        check({tag, " s1_pfn"},   s1_pfn,   e.pfn);
        check({tag, " s1_c"},     s1_c,     e.c);
        check({tag, " s1_d"},     s1_d,     e.d);
        check({tag, " s1_v"},     s1_v,     e.v);
        check({tag, " s1_multi"}, s1_multi, e.multi);
        $display("lookup %s vpn2=%05h odd=%0d asid=%02h -> found=%0d idx=%0d pfn=%05h",
                 tag, v.vpn2, v.odd, v.asid, s1_found, s1_index, s1_pfn);
    endtask

    function automatic lk_t miss(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        lk_t m;
        m = '{vpn2, odd, asid, 1'b0, 4'd0, 20'd0, 3'd0, 1'b0, 1'b0, 1'b0};
        return m;
    endfunction

    task automatic set_w(input int idx, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                         input logic d0, input logic v0, input logic [19:0] pfn1,
                         input logic [2:0] c1, input logic d1, input logic v1);
        we = 1'b1; w_index = IDXW'(idx); w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic do_write(input int idx, input logic [18:0] vpn2, input logic [7:0] asid,
                            input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                            input logic d0, input logic v0, input logic [19:0] pfn1,
                            input logic [2:0] c1, input logic d1, input logic v1);
        set_w(idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
        @(posedge clk); #1;
        we = 1'b0;
        $display("write idx=%0d vpn2=%05h asid=%02h g=%0d", idx, vpn2, asid, g);
    endtask

    task automatic wait_idle(input string tag, input int exp_done);
        int dones = 0;
        for (int n = 0; n < 64 && invall_busy; n++) begin
            @(negedge clk);
            if (invall_done) dones++;
        end
        check({tag, " sweep_ends"}, invall_busy, 1'b0);
        check({tag, " done_pulses"}, dones, exp_done);
    endtask

    lk_t vecs[6];

    initial begin
        resetn = 1'b0; we = 1'b0; invall_req = 1'b0; r_index = 4'd5;
        w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0; w_pfn0 = '0; w_c0 = '0;
        w_d0 = 1'b0; w_v0 = 1'b0; w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
        s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
        s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;

        // Reset state
        #2;
        check("rst s0_found", s0_found, 1'b0);
        check("rst s1_found", s1_found, 1'b0);
        check("rst s0_multi", s0_multi, 1'b0);
        check("rst r_vpn2", r_vpn2, 19'd0);
        check("rst r_pfn1", r_pfn1, 20'd0);
        check("rst busy", invall_busy, 1'b0);
        check("rst done", invall_done, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        lookup("rst0", miss(19'd0, 1'b0, 8'd0));

        // Basic contents: entry 3 private, entries 9 and 2 share vpn2/asid
        do_write(3, 19'h12345, 8'h05, 1'b0, 20'h11111, 3'd2, 1'b0, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1);
        do_write(9, 19'h00777, 8'h10, 1'b0, 20'h00900, 3'd4, 1'b0, 1'b1, 20'h00901, 3'd0, 1'b0, 1'b0);
        do_write(2, 19'h00777, 8'h10, 1'b0, 20'h00200, 3'd1, 1'b1, 1'b1, 20'h00201, 3'd0, 1'b0, 1'b0);

        vecs[0] = '{19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b0};
        vecs[1] = miss(19'h12345, 1'b1, 8'h06);
        vecs[2] = '{19'h12345, 1'b0, 8'h05, 1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[3] = miss(19'h12344, 1'b1, 8'h05);
        vecs[4] = '{19'h00777, 1'b0, 8'h10, 1'b1, 4'd2, 20'h00200, 3'd1, 1'b1, 1'b1, MH};
        vecs[5] = miss(19'h00777, 1'b1, 8'h11);
        for (int k = 0; k < 6; k++) lookup($sformatf("tbl%0d", k), vecs[k]);

        // Global rewrite of entry 3: same-cycle lookup sees the old contents
        set_w(3, 19'h12345, 8'h05, 1'b1, 20'h11111, 3'd2, 1'b0, 1'b0, 20'h22222, 3'd3, 1'b1, 1'b1);
        s1_vpn2 = 19'h12345; s1_odd_page = 1'b1; s1_asid = 8'h06;
        s0_vpn2 = 19'h12345; s0_odd_page = 1'b1; s0_asid = 8'h05;
        #1;
        check("wr_same s1_found_old", s1_found, 1'b0);
        check("wr_same s0_pfn_old", s0_pfn, 20'hABCDE);
        @(posedge clk); #1;
        we = 1'b0;
        check("wr_after s1_found", s1_found, 1'b1);
        check("wr_after s1_index", s1_index, 4'd3);
        check("wr_after s1_pfn", s1_pfn, 20'h22222);
        $display("same-cycle write/lookup on idx 3 done");
        r_index = 4'd3;
        #1;
        check("rd3 r_vpn2", r_vpn2, 19'h12345);
        check("rd3 r_asid", r_asid, 8'h05);
        check("rd3 r_g", r_g, 1'b1);
        check("rd3 r_pfn0", r_pfn0, 20'h11111);
        check("rd3 r_c0", r_c0, 3'd2);
        check("rd3 r_pfn1", r_pfn1, 20'h22222);

        // Fill all entries, then a full sweep with req held through the done cycle
        for (int i = 0; i < TLBNUM; i++)
            do_write(i, 19'h00100 + 19'(i), 8'h01, 1'b0, 20'(i), 3'd0, 1'b0, 1'b1,
                     20'(i + 16), 3'd0, 1'b0, 1'b1);
        invall_req = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < TLBNUM; k++) begin
            @(negedge clk);
            check($sformatf("sw1 busy[%0d]", k), invall_busy, 1'b1);
            check($sformatf("sw1 done[%0d]", k), invall_done, k == TLBNUM - 1);
            @(posedge clk); #1;
        end
        invall_req = 1'b0;
        @(negedge clk);
        check("sw1 busy_after", invall_busy, 1'b0);
        check("sw1 done_after", invall_done, 1'b0);
        $display("sweep 1 complete");
        for (int i = 0; i < TLBNUM; i++)
            lookup($sformatf("swept%0d", i), miss(19'h00100 + 19'(i), 1'(i & 1), 8'h01));
        r_index = 4'd5;
        #1;
        check("rd5 r_vpn2", r_vpn2, 19'h00105);
        check("rd5 r_pfn0", r_pfn0, 20'h5);
        check("rd5 r_v0", r_v0, 1'b0);
        check("rd5 r_v1", r_v1, 1'b0);

        // Writes during a sweep: idx0 behind ptr survives, idx10 ahead is cleared, idx7 at ptr wins
        do_write(0, 19'h00200, 8'h01, 1'b0, 20'h0, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b1);
        invall_req = 1'b1;
        @(posedge clk); #1;
        invall_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        set_w(0, 19'h00300, 8'h01, 1'b0, 20'h30000, 3'd5, 1'b1, 1'b1, 20'h30001, 3'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_w(10, 19'h0030A, 8'h01, 1'b0, 20'h3000A, 3'd0, 1'b0, 1'b1, 20'h3000B, 3'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        we = 1'b0;
        @(posedge clk); #1;
        set_w(7, 19'h00307, 8'h01, 1'b0, 20'h30007, 3'd6, 1'b0, 1'b1, 20'h30008, 3'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        we = 1'b0;
        wait_idle("sw2", 1);
        $display("sweep 2 complete");
        lookup("sw2 idx0", '{19'h00300, 1'b0, 8'h01, 1'b1, 4'd0, 20'h30000, 3'd5, 1'b1, 1'b1, 1'b0});
        lookup("sw2 idx10", miss(19'h0030A, 1'b0, 8'h01));
        lookup("sw2 idx7", '{19'h00307, 1'b0, 8'h01, 1'b1, 4'd7, 20'h30007, 3'd6, 1'b0, 1'b1, 1'b0});
        lookup("sw2 old0", miss(19'h00200, 1'b0, 8'h01));
        r_index = 4'd10;
        #1;
        check("rd10 r_vpn2", r_vpn2, 19'h0030A);
        check("rd10 r_v0", r_v0, 1'b0);
        check("rd10 r_v1", r_v1, 1'b0);

        // Reset asserted mid-sweep at ptr=7
        do_write(1, 19'h00401, 8'h01, 1'b0, 20'h4, 3'd0, 1'b0, 1'b1, 20'h5, 3'd0, 1'b0, 1'b1);
        invall_req = 1'b1;
        @(posedge clk); #1;
        invall_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("sw3 busy_before_rst", invall_busy, 1'b1);
        resetn = 1'b0;
        #1;
        check("sw3 busy_in_rst", invall_busy, 1'b0);
        check("sw3 done_in_rst", invall_done, 1'b0);
        r_index = 4'd0;
        #1;
        check("sw3 r0_vpn2", r_vpn2, 19'd0);
        check("sw3 r0_pfn0", r_pfn0, 20'd0);
        lookup("sw3 idx1", miss(19'h00401, 1'b0, 8'h01));
        @(posedge clk); #1;
        resetn = 1'b1;
        begin
            int seen = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (invall_busy || invall_done) seen++;
            end
            check("sw3 no_resume", seen, 0);
        end
        $display("reset mid-sweep checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
